// File: rtl/ni_axi4lite_writer_pkg.sv
// ni_pkg: definitions shared by the NI AXI4-Lite writer and the rest of the NI.
//   - state_e : writer FSM state encoding
//   - RESP_*  : AXI write-response (BRESP) codes
//   - entry field positions of a 64-bit transmit-FIFO entry {data, addr}
//   - resp_is_error() : any response other than OKAY counts as an error
package ni_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DATA_MSB = 63;
  localparam int DATA_LSB = 32;
  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 0;

  // EXOKAY is not expected from a plain AXI4-Lite target, so it is flagged too.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ni_axi4lite_writer_if.sv
// AXI4-Lite write channels (AW, W, B) between the NI writer and its target.
//   master : drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready
//   slave  : drives awready, wready, bresp/bvalid
interface ni_axi4lite_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ni_axi4lite_writer.sv
// ni_axi4lite_writer: outbound AXI4-Lite master of the network interface.
// Pops one {data, addr} entry from the transmit FIFO and issues one AXI4-Lite
// write per entry, reporting response errors, handshake timeouts and a count.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   fifo_data/empty    : FIFO head entry (valid the cycle after a pop), empty flag
//   fifo_read_en       : pop strobe, issued from IDLE only
//   axi (master)       : AW/W/B channels
//   err_clr            : clears err and timeout (a simultaneous set wins)
//   busy, err, err_addr, timeout, txn_count : status toward the core
module ni_axi4lite_writer
  import ni_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_read_en,
  ni_axi4lite_writer_if.master axi,
  input  logic               err_clr,
  output logic               busy,
  output logic               err,
  output logic [ADDR_W-1:0]  err_addr,
  output logic               timeout,
  output logic [15:0]        txn_count
);

  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         txn_count_q, txn_count_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
  logic                aw_done_s, w_done_s, waiting_s, err_set_s, tmo_set_s;

  // Next-state, datapath and status computation.
  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    err_addr_d   = err_addr_q;
    txn_count_d  = txn_count_q;
    tmo_cnt_d    = tmo_cnt_q;
    fifo_read_en = 1'b0;
    waiting_s    = 1'b0;
    err_set_s    = 1'b0;
    // A channel is done once its valid has dropped or is accepted this cycle.
    aw_done_s    = !awvalid_q || axi.awready;
    w_done_s     = !wvalid_q  || axi.wready;

    case (state_q)
      S_IDLE: begin
        fifo_read_en = !fifo_empty;
        if (!fifo_empty) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        awaddr_d  = ADDR_W'(fifo_data[ADDR_MSB:ADDR_LSB]);
        wdata_d   = DATA_W'(fifo_data[DATA_MSB:DATA_LSB]);
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        tmo_cnt_d = 8'd0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (axi.awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (axi.wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_s && w_done_s) begin
          state_d   = S_RESP;
          bready_d  = 1'b1;
          tmo_cnt_d = 8'd0;
        end else begin
          waiting_s = 1'b1;
        end
      end
      S_RESP: begin
        if (axi.bvalid) begin
          bready_d    = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = S_IDLE;
          if (resp_is_error(axi.bresp)) begin
            err_set_s  = 1'b1;
            err_addr_d = awaddr_q;
          end else begin
            err_set_s  = 1'b0;
          end
        end else begin
          waiting_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Saturating wait counter; the transaction itself is never aborted.
    if (waiting_s && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_d;
    end
    // Fires on the TIMEOUT-th consecutive waiting cycle; a limit of 0 never matches.
    tmo_set_s = waiting_s && (TIMEOUT != 0) && (({1'b0, tmo_cnt_q} + 9'd1) == TMO_LIMIT);

    // Sticky flags: a set in the same cycle as err_clr takes priority.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (tmo_set_s) begin
      timeout_d = 1'b1;
    end else if (err_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      timeout_q   <= 1'b0;
      txn_count_q <= 16'd0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      timeout_q   <= timeout_d;
      txn_count_q <= txn_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign err_addr    = err_addr_q;
  assign timeout     = timeout_q;
  assign txn_count   = txn_count_q;

endmodule
